axi_burst_addr_gen: RTL

Parametrised AXI burst address generator for the AXI2APB bridge. It accepts one AXI burst command (address, 8-bit length, size, type) through a valid/ready handshake. It then emits one beat address per downstream handshake, each with a one-hot slave select and a decode-error flag. It covers full AXI4 FIXED/INCR/WRAP semantics across NUM_SLV configurable regions. Out-of-range beats are flagged for SLVERR/DECERR generation and are never remapped.

---
 rtl/axi_burst_addr_gen.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Brief    : AXI4 burst address generator for the AXI2APB bridge. Accepts
//            one burst command and emits one beat address per downstream
//            handshake. Each beat carries a one-hot slave select, a decode
//            error flag, a last flag and a beat index. Supports FIXED, INCR
//            and WRAP bursts.
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen #(
  parameter int                            ADDR_WIDTH    = 32,
  parameter int                            DATA_WIDTH    = 32,
  parameter int                            NUM_SLV       = 2,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE      = {32'h0002_F000, 32'h0001_F000},
  parameter int                            SLV_SIZE_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [1:0]            cmd_burst_i,
  // beat channel
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [NUM_SLV-1:0]    beat_sel_o,
  output logic                  beat_err_o,
  output logic                  beat_last_o,
  output logic [7:0]            beat_idx_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]            c_S_IDLE   = 1'b0;
  localparam logic [0:0]            c_S_BURST  = 1'b1;

  localparam logic [1:0]            c_FIXED    = 2'b00;
  localparam logic [1:0]            c_INCR     = 2'b01;
  localparam logic [1:0]            c_WRAP     = 2'b10;
  localparam logic [1:0]            c_RSVD     = 2'b11;

  localparam logic [2:0]            c_MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);
  localparam int                    c_TAG_W    = ADDR_WIDTH - SLV_SIZE_LOG2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_idx;
  logic [7:0]            r_len;
  logic [2:0]            r_size_eff;
  logic [1:0]            r_burst_eff;
  logic                  r_illegal;
  logic [ADDR_WIDTH-1:0] r_wrap_low;
  logic [ADDR_WIDTH-1:0] r_wrap_mask;

  // --------------------------------------------------------------------------
  // Command-side decode (evaluated on the incoming command)
  // --------------------------------------------------------------------------
  logic                  w_cmd_fire;
  logic                  w_beat_fire;
  logic [2:0]            w_cmd_size_eff;
  logic [ADDR_WIDTH-1:0] w_cmd_bytes;
  logic [ADDR_WIDTH-1:0] w_cmd_wsize;
  logic [ADDR_WIDTH-1:0] w_cmd_wmask;
  logic                  w_size_bad;
  logic                  w_rsvd;
  logic                  w_wrap_len_ok;
  logic                  w_wrap_unaligned;
  logic                  w_wrap_bad;
  logic                  w_cmd_illegal;
  logic [1:0]            w_cmd_burst_eff;

  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign w_beat_fire = beat_valid_o && beat_ready_i;

  // Classify the incoming command: effective size, wrap window, legality
  always_comb begin
    w_size_bad       = (cmd_size_i > c_MAX_SIZE);
    w_cmd_size_eff   = w_size_bad ? c_MAX_SIZE : cmd_size_i;
    w_cmd_bytes      = c_ONE << w_cmd_size_eff;
    // wrap window = number of beats times bytes per beat
    w_cmd_wsize      = ADDR_WIDTH'({1'b0, cmd_len_i} + 9'd1) << w_cmd_size_eff;
    w_cmd_wmask      = w_cmd_wsize - c_ONE;
    w_rsvd           = (cmd_burst_i == c_RSVD);
    w_wrap_len_ok    = (cmd_len_i == 8'd1) || (cmd_len_i == 8'd3) ||
                       (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);
    w_wrap_unaligned = |(cmd_addr_i & (w_cmd_bytes - c_ONE));
    w_wrap_bad       = (cmd_burst_i == c_WRAP) && (!w_wrap_len_ok || w_wrap_unaligned);
    w_cmd_illegal    = w_size_bad || w_rsvd || w_wrap_bad;
    // an illegal WRAP or a reserved type falls back to INCR so the beat
    // count is honoured and the addresses still walk forward
    if (w_cmd_illegal && (cmd_burst_i != c_FIXED)) begin
      w_cmd_burst_eff = c_INCR;
    end else begin
      w_cmd_burst_eff = cmd_burst_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-beat address from the latched command
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_incr_next;
  logic [ADDR_WIDTH-1:0] w_wrap_next;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Step the beat address according to the effective burst type
  always_comb begin
    w_bytes     = c_ONE << r_size_eff;
    // INCR: align down first, so an unaligned start is corrected on beat 1
    w_incr_next = (r_addr & ~(w_bytes - c_ONE)) + w_bytes;
    w_wrap_next = r_wrap_low | ((r_addr + w_bytes) & r_wrap_mask);
    case (r_burst_eff)
      c_FIXED: w_next_addr = r_addr;
      c_WRAP:  w_next_addr = w_wrap_next;
      default: w_next_addr = w_incr_next;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM and beat registers
  // --------------------------------------------------------------------------
  // Accept a command in IDLE, walk beats in BURST, return to IDLE on last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_S_IDLE;
      r_addr      <= '0;
      r_idx       <= 8'd0;
      r_len       <= 8'd0;
      r_size_eff  <= 3'd0;
      r_burst_eff <= c_FIXED;
      r_illegal   <= 1'b0;
      r_wrap_low  <= '0;
      r_wrap_mask <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_cmd_fire) begin
            r_state     <= c_S_BURST;
            r_addr      <= cmd_addr_i;
            r_idx       <= 8'd0;
            r_len       <= cmd_len_i;
            r_size_eff  <= w_cmd_size_eff;
            r_burst_eff <= w_cmd_burst_eff;
            r_illegal   <= w_cmd_illegal;
            r_wrap_low  <= cmd_addr_i & ~w_cmd_wmask;
            r_wrap_mask <= w_cmd_wmask;
          end
        end
        c_S_BURST: begin
          if (w_beat_fire) begin
            if (beat_last_o) begin
              r_state <= c_S_IDLE;
            end else begin
              r_idx  <= r_idx + 8'd1;
              r_addr <= w_next_addr;
            end
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Region decode on the registered beat address
  // --------------------------------------------------------------------------
  logic [NUM_SLV-1:0] w_sel;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_dec
    assign w_sel[g] = (r_addr[ADDR_WIDTH-1:SLV_SIZE_LOG2] ==
                       SLV_BASE[g*ADDR_WIDTH + SLV_SIZE_LOG2 +: c_TAG_W]);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_ready_o  = (r_state == c_S_IDLE);
  assign beat_valid_o = (r_state == c_S_BURST);
  assign beat_addr_o  = r_addr;
  assign beat_sel_o   = w_sel;
  assign beat_err_o   = r_illegal || !(|w_sel);
  assign beat_last_o  = (r_idx == r_len);
  assign beat_idx_o   = r_idx;

endmodule
`default_nettype wire
